// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: data memory req/ack and register write port.
// Optional misaligned-access trap enabled by defining MISALIGN_CHECK_EN.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wreg,
  input  logic [REG_AW-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [2:0]        in_funct3,
  input  logic [DATA_W-1:0] in_sdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              we,
  output logic [REG_AW-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_waddr,
  output logic              exc_misalign,
  output logic [DATA_W-1:0] exc_addr
);

  typedef enum logic {IDLE, MEM} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              is_load;
  logic              is_store;
  logic              is_mem;
  logic              misal;
  logic [2:0]        lat_f3;
  logic [1:0]        lat_off;
  logic [3:0]        be_nxt;
  logic [DATA_W-1:0] sdata_nxt;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;

  assign in_ready = (state == IDLE) && rst;
  assign accept   = in_valid && in_ready;
  assign is_load  = in_load;
  assign is_store = in_store && !in_load;
  assign is_mem   = is_load || is_store;

  // misaligned-access detection (constant 0 when the trap is disabled)
  always_comb begin
    misal = 1'b0;
`ifdef MISALIGN_CHECK_EN
    if (is_load) begin
      case (in_funct3)
        3'b000, 3'b100: misal = 1'b0;
        3'b001, 3'b101: misal = in_result[0];
        default:        misal = |in_result[1:0];
      endcase
    end else if (is_store) begin
      case (in_funct3)
        3'b000:  misal = 1'b0;
        3'b001:  misal = in_result[0];
        default: misal = |in_result[1:0];
      endcase
    end
`endif
  end

  // store byte enables and lane-replicated write data
  always_comb begin
    be_nxt    = 4'b1111;
    sdata_nxt = in_sdata;
    case (in_funct3)
      3'b000: begin
        be_nxt    = 4'b0001 << in_result[1:0];
        sdata_nxt = {4{in_sdata[7:0]}};
      end
      3'b001: begin
        be_nxt    = in_result[1] ? 4'b1100 : 4'b0011;
        sdata_nxt = {2{in_sdata[15:0]}};
      end
      default: begin
        be_nxt    = 4'b1111;
        sdata_nxt = in_sdata;
      end
    endcase
  end

  // load lane selection and sign/zero extension
  always_comb begin
    ld_byte = mem_rdata[{lat_off, 3'b000} +: 8];
    ld_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_f3)
      3'b000:  ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next state: enter MEM on an issued access, leave on ack
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && is_mem && !misal) state_nxt = MEM;
      MEM:  if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // memory bus, writeback and pending-load registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      pend_valid <= 1'b0;
      pend_waddr <= '0;
      lat_f3     <= '0;
      lat_off    <= '0;
    end else begin
      we <= 1'b0;
      if (accept && is_mem && !misal) begin
        mem_req    <= 1'b1;
        mem_we     <= is_store;
        mem_addr   <= {in_result[DATA_W-1:2], 2'b00};
        mem_be     <= is_store ? be_nxt : 4'b1111;
        mem_wdata  <= sdata_nxt;
        pend_valid <= is_load && in_wreg && (in_waddr != '0);
        pend_waddr <= in_waddr;
        lat_f3     <= in_funct3;
        lat_off    <= in_result[1:0];
      end else if (accept && !is_mem) begin
        we    <= in_wreg && (in_waddr != '0);
        waddr <= in_waddr;
        wdata <= in_result;
      end
      if (state == MEM && mem_ack) begin
        mem_req    <= 1'b0;
        pend_valid <= 1'b0;
        if (pend_valid) begin
          we    <= 1'b1;
          waddr <= pend_waddr;
          wdata <= ld_data;
        end
      end
    end
  end

`ifdef MISALIGN_CHECK_EN
  // one-cycle trap pulse with the faulting address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_misalign <= 1'b0;
      exc_addr     <= '0;
    end else begin
      exc_misalign <= accept && misal;
      if (accept && misal) exc_addr <= in_result;
    end
  end
`else
  assign exc_misalign = 1'b0;
  assign exc_addr     = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: register writes queued at drive time,
// popped by a writeback monitor.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wreg = 1'b0;
  logic [4:0]  in_waddr = '0;
  logic [31:0] in_result = '0;
  logic        in_load = 1'b0;
  logic        in_store = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_sdata = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        pend_valid;
  logic [4:0]  pend_waddr;
  logic        exc_misalign;
  logic [31:0] exc_addr;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t sb_q[$];
  wr_t sb_e;
  int  tests = 0;
  int  fails = 0;

  mem_wb_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wreg(in_wreg), .in_waddr(in_waddr),
    .in_result(in_result), .in_load(in_load),
    .in_store(in_store), .in_funct3(in_funct3),
    .in_sdata(in_sdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .pend_valid(pend_valid), .pend_waddr(pend_waddr),
    .exc_misalign(exc_misalign), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  // writeback monitor: every write must match the oldest queued entry
  always @(negedge clk) begin
    if (we === 1'b1) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL wb_unexpected got waddr=%0d wdata=%h required no write",
                 waddr, wdata);
      end else begin
        sb_e = sb_q.pop_front();
        if (waddr !== sb_e.a || wdata !== sb_e.d) begin
          fails++;
          $display("FAIL wb_data got %0d/%h required %0d/%h",
                   waddr, wdata, sb_e.a, sb_e.d);
        end
      end
    end
  end

  task automatic drive(input logic ld, input logic st, input logic wr,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] sd);
    in_valid  = 1'b1;
    in_load   = ld;
    in_store  = st;
    in_wreg   = wr;
    in_funct3 = f3;
    in_waddr  = rd;
    in_result = res;
    in_sdata  = sd;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_load  = 1'b0;
    in_store = 1'b0;
    in_wreg  = 1'b0;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b required 0", in_ready); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b required 0", mem_req); end
    tests++; if (pend_valid !== 1'b0) begin fails++; $display("FAIL rst_pend got %b required 0", pend_valid); end
    tests++; if (we !== 1'b0 || wdata !== 32'h0) begin fails++; $display("FAIL rst_wb got %b/%h required 0/0", we, wdata); end
    tests++; if (mem_addr !== 32'h0 || mem_be !== 4'h0) begin fails++; $display("FAIL rst_bus got %h/%b required 0/0", mem_addr, mem_be); end
    rst = 1'b1;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b required 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rds[3];
    logic [31:0] rs[3];
    logic        ew[3];
    rds = '{5'd5, 5'd0, 5'd7};
    rs  = '{32'h11111111, 32'h22222222, 32'h33333333};
    ew  = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        tests++; if (we !== ew[i-1]) begin fails++; $display("FAIL b2b_we%0d got %b required %b", i-1, we, ew[i-1]); end
      end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d got %b required 1", i, in_ready); end
      drive(1'b0, 1'b0, 1'b1, 3'b000, rds[i], rs[i], 32'h0);
      if (rds[i] != 5'd0) push(rds[i], rs[i]);
      @(negedge clk);
    end
    idle();
    tests++; if (we !== ew[2]) begin fails++; $display("FAIL b2b_we2 got %b required %b", we, ew[2]); end
    @(negedge clk);
    tests++; if (we !== 1'b0) begin fails++; $display("FAIL b2b_we_end got %b required 0", we); end
  endtask

  task automatic test_lb();
    drive(1'b1, 1'b0, 1'b1, 3'b000, 5'd3, 32'h00001003, 32'h0);
    push(5'd3, 32'hFFFFFF80);
    @(negedge clk);
    idle();
    tests++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin fails++; $display("FAIL lb_req got %b/%b required 1/0", mem_req, mem_we); end
    tests++; if (mem_addr !== 32'h00001000) begin fails++; $display("FAIL lb_addr got %h required 00001000", mem_addr); end
    tests++; if (pend_valid !== 1'b1 || pend_waddr !== 5'd3) begin fails++; $display("FAIL lb_pend got %b/%0d required 1/3", pend_valid, pend_waddr); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL lb_ready got %b required 0", in_ready); end
    mem_ack   = 1'b1;
    mem_rdata = 32'h80AABBCC;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++; if (we !== 1'b1) begin fails++; $display("FAIL lb_we got %b required 1", we); end
    tests++; if (mem_req !== 1'b0 || pend_valid !== 1'b0) begin fails++; $display("FAIL lb_done got %b/%b required 0/0", mem_req, pend_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL lb_ready_after got %b required 1", in_ready); end
  endtask

  task automatic test_lhu_delay();
    mem_rdata = 32'h0;
    drive(1'b1, 1'b0, 1'b1, 3'b101, 5'd9, 32'h00002002, 32'h0);
    push(5'd9, 32'h00008001);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle();
      tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h00002000 || mem_be !== 4'b1111) begin fails++; $display("FAIL lhu_hold%0d got %b/%h/%b required 1/00002000/1111", c, mem_req, mem_addr, mem_be); end
      tests++; if (in_ready !== 1'b0 || we !== 1'b0) begin fails++; $display("FAIL lhu_stall%0d got %b/%b required 0/0", c, in_ready, we); end
      if (c == 3) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h8001FFFF;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    tests++; if (we !== 1'b1 || mem_req !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL lhu_done got %b/%b/%b required 1/0/1", we, mem_req, in_ready); end
  endtask

  task automatic test_stores();
    logic [31:0] ad[2];
    logic [31:0] sd[2];
    logic [2:0]  f3[2];
    logic [3:0]  eb[2];
    logic [31:0] ewd[2];
    ad  = '{32'h00003001, 32'h00003002};
    sd  = '{32'h12345678, 32'h0000ABCD};
    f3  = '{3'b000, 3'b001};
    eb  = '{4'b0010, 4'b1100};
    ewd = '{32'h78787878, 32'hABCDABCD};
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, f3[i], 5'd4, ad[i], sd[i]);
      @(negedge clk);
      idle();
      tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h00003000) begin fails++; $display("FAIL st%0d_req got %b/%b/%h required 1/1/00003000", i, mem_req, mem_we, mem_addr); end
      tests++; if (mem_be !== eb[i] || mem_wdata !== ewd[i]) begin fails++; $display("FAIL st%0d_lanes got %b/%h required %b/%h", i, mem_be, mem_wdata, eb[i], ewd[i]); end
      tests++; if (pend_valid !== 1'b0) begin fails++; $display("FAIL st%0d_pend got %b required 0", i, pend_valid); end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      tests++; if (we !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL st%0d_done got %b/%b required 0/0", i, we, mem_req); end
    end
  endtask

  task automatic test_reset_mid_load();
    drive(1'b1, 1'b0, 1'b1, 3'b010, 5'd6, 32'h00005000, 32'h0);
    @(negedge clk);
    idle();
    tests++; if (mem_req !== 1'b1 || pend_valid !== 1'b1) begin fails++; $display("FAIL rml_req got %b/%b required 1/1", mem_req, pend_valid); end
    #2 rst = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0 || pend_valid !== 1'b0) begin fails++; $display("FAIL rml_abort got %b/%b required 0/0", mem_req, pend_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rml_ready got %b required 0", in_ready); end
    @(negedge clk);
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++; if (we !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL rml_late_ack got %b/%b/%b required 0/0/1", we, mem_req, in_ready); end
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b0, 1'b1, 3'b010, 5'd8, 32'h00004002, 32'h0);
`ifdef MISALIGN_CHECK_EN
    @(negedge clk);
    idle();
    tests++; if (exc_misalign !== 1'b1 || exc_addr !== 32'h00004002) begin fails++; $display("FAIL mis_exc got %b/%h required 1/00004002", exc_misalign, exc_addr); end
    tests++; if (mem_req !== 1'b0 || we !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL mis_noreq got %b/%b/%b required 0/0/1", mem_req, we, in_ready); end
    @(negedge clk);
    tests++; if (exc_misalign !== 1'b0 || we !== 1'b0) begin fails++; $display("FAIL mis_pulse got %b/%b required 0/0", exc_misalign, we); end
`else
    push(5'd8, 32'hDEADBEEF);
    @(negedge clk);
    idle();
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h00004000) begin fails++; $display("FAIL mis_req got %b/%h required 1/00004000", mem_req, mem_addr); end
    tests++; if (exc_misalign !== 1'b0) begin fails++; $display("FAIL mis_exc got %b required 0", exc_misalign); end
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++; if (we !== 1'b1 || exc_addr !== 32'h0) begin fails++; $display("FAIL mis_lw got %b/%h required 1/0", we, exc_addr); end
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_lb();
    test_lhu_delay();
    test_stores();
    test_reset_mid_load();
    test_misalign();
    @(negedge clk);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain got %0d pending required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
